// File: rtl/conv_fc_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv_fc_seq
// Purpose  : Frame-level sequencer for the conv -> FC inference path. Issues
//            NTILE input tiles to the conv unit, steps the FC weight-tile
//            address on every conv->FC transfer, steers the result
//            accumulator from FC partial-sum beats and hands the finished
//            frame result downstream over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module conv_fc_seq #(
    parameter int NTILE  = 26,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_conv_valid,
    input  logic              i_conv_ready,
    output logic [ADDR_W-1:0] o_conv_tile,
    input  logic              i_mid_valid,
    input  logic              i_mid_ready,
    output logic [ADDR_W-1:0] o_fc_waddr,
    input  logic              i_fc_valid,
    output logic              o_fc_ready,
    output logic              o_acc_clr,
    output logic              o_acc_en,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_done
);

    // Counters span 0..NTILE, and NTILE may equal 2^ADDR_W, hence one extra bit.
    localparam int c_cnt_w = ADDR_W + 1;

    localparam logic [c_cnt_w-1:0] c_ntile     = c_cnt_w'(NTILE);
    localparam logic [c_cnt_w-1:0] c_ntile_m1  = c_cnt_w'(NTILE - 1);
    localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(NTILE - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_out   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_iss;
    logic [c_cnt_w-1:0] r_mid;
    logic [c_cnt_w-1:0] r_fc;
    logic [ADDR_W-1:0]  r_waddr;

    logic w_active;
    logic w_conv_valid;
    logic w_conv_fire;
    logic w_fc_ready;
    logic w_fc_beat;
    logic w_mid_fire;
    logic w_iss_done;
    logic w_fc_done;

    // Handshake qualifiers; the mid counter saturates so extra transfers are dropped.
    assign w_active     = (r_state == c_st_run) || (r_state == c_st_drain);
    assign w_conv_valid = (r_state == c_st_run) && (r_iss < c_ntile);
    assign w_conv_fire  = w_conv_valid && i_conv_ready;
    assign w_fc_ready   = w_active && (r_fc < c_ntile);
    assign w_fc_beat    = w_fc_ready && i_fc_valid;
    assign w_mid_fire   = w_active && i_mid_valid && i_mid_ready && (r_mid < c_ntile);

    // "Done after this edge" views so the final fire and the state change coincide.
    assign w_iss_done = (r_iss == c_ntile) || (w_conv_fire && (r_iss == c_ntile_m1));
    assign w_fc_done  = (r_fc == c_ntile) || (w_fc_beat && (r_fc == c_ntile_m1));

    assign o_conv_tile = r_iss[ADDR_W-1:0];
    assign o_fc_waddr  = r_waddr;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a frame may skip DRAIN when the FC side finished first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (i_start) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_iss_done) begin
                    w_state_nxt = w_fc_done ? c_st_out : c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_fc_done) begin
                    w_state_nxt = c_st_out;
                end
            end
            c_st_out: begin
                if (i_res_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Output decode; accumulator control is combinational on the FC beat.
    always_comb begin
        o_busy       = (r_state != c_st_idle);
        o_conv_valid = w_conv_valid;
        o_fc_ready   = w_fc_ready;
        o_res_valid  = (r_state == c_st_out);
        o_done       = (r_state == c_st_out) && i_res_ready;
        o_acc_clr    = w_fc_beat && (r_fc == '0);
        o_acc_en     = w_fc_beat && (r_fc != '0);
    end

    // Frame counters and weight-tile address; cleared on reset and on a new start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iss   <= '0;
            r_mid   <= '0;
            r_fc    <= '0;
            r_waddr <= '0;
        end else if (r_state == c_st_idle) begin
            if (i_start) begin
                r_iss   <= '0;
                r_mid   <= '0;
                r_fc    <= '0;
                r_waddr <= '0;
            end
        end else begin
            if (w_conv_fire) begin
                r_iss <= r_iss + 1'b1;
            end
            if (w_mid_fire) begin
                r_mid   <= r_mid + 1'b1;
                r_waddr <= (r_waddr == c_last_addr) ? '0 : r_waddr + 1'b1;
            end
            if (w_fc_beat) begin
                r_fc <= r_fc + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_fc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_fc_seq
// Purpose  : Self-checking bench for conv_fc_seq. Two instances (NTILE=26 and
//            NTILE=2) share one directed stimulus; a frame-level model checks
//            every output each cycle, and directed literals pin the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_fc_seq;

    localparam int N0  = 26;
    localparam int AW0 = 5;
    localparam int N1  = 2;
    localparam int AW1 = 1;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic start      = 1'b0;
    logic conv_ready = 1'b1;
    logic mid_valid  = 1'b0;
    logic mid_ready  = 1'b1;
    logic fc_valid   = 1'b0;
    logic res_ready  = 1'b1;

    logic busy [2];
    logic cv   [2];
    logic fcr  [2];
    logic clr  [2];
    logic en   [2];
    logic rv   [2];
    logic done [2];
    logic [AW0-1:0] tile0;
    logic [AW0-1:0] wa0;
    logic [AW1-1:0] tile1;
    logic [AW1-1:0] wa1;

    int tests = 0;
    int fails = 0;

    // Frame model state per instance: phase 0 idle, 1 run, 2 drain, 3 out.
    int nt      [2] = '{N0, N1};
    int m_phase [2] = '{0, 0};
    int m_iss   [2] = '{0, 0};
    int m_mid   [2] = '{0, 0};
    int m_fc    [2] = '{0, 0};
    int m_wa    [2] = '{0, 0};

    // Observed event statistics.
    int n_fire [2] = '{0, 0};
    int n_clr  [2] = '{0, 0};
    int n_en   [2] = '{0, 0};
    int n_done [2] = '{0, 0};
    int n_resv [2] = '{0, 0};

    always #5 clk = ~clk;

    conv_fc_seq #(.NTILE(N0), .ADDR_W(AW0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy[0]),
        .o_conv_valid(cv[0]), .i_conv_ready(conv_ready), .o_conv_tile(tile0),
        .i_mid_valid(mid_valid), .i_mid_ready(mid_ready), .o_fc_waddr(wa0),
        .i_fc_valid(fc_valid), .o_fc_ready(fcr[0]), .o_acc_clr(clr[0]),
        .o_acc_en(en[0]), .o_res_valid(rv[0]), .i_res_ready(res_ready),
        .o_done(done[0])
    );

    conv_fc_seq #(.NTILE(N1), .ADDR_W(AW1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy[1]),
        .o_conv_valid(cv[1]), .i_conv_ready(conv_ready), .o_conv_tile(tile1),
        .i_mid_valid(mid_valid), .i_mid_ready(mid_ready), .o_fc_waddr(wa1),
        .i_fc_valid(fc_valid), .o_fc_ready(fcr[1]), .o_acc_clr(clr[1]),
        .o_acc_en(en[1]), .o_res_valid(rv[1]), .i_res_ready(res_ready),
        .o_done(done[1])
    );

    task automatic chk(input string nm, input int k, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s [dut%0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compare current outputs against the model, then advance the model one cycle.
    task automatic check_and_step(input int k);
        int n;
        int e_cv;
        int e_fcr;
        int e_beat;
        int a_tile;
        int a_wa;
        n      = nt[k];
        a_tile = (k == 0) ? int'(tile0) : int'(tile1);
        a_wa   = (k == 0) ? int'(wa0) : int'(wa1);
        e_cv   = int'(m_phase[k] == 1 && m_iss[k] < n);
        e_fcr  = int'((m_phase[k] == 1 || m_phase[k] == 2) && m_fc[k] < n);
        e_beat = e_fcr & int'(fc_valid);

        chk("busy", k, int'(busy[k]), int'(m_phase[k] != 0));
        chk("conv_valid", k, int'(cv[k]), e_cv);
        if (e_cv != 0) chk("conv_tile", k, a_tile, m_iss[k]);
        chk("fc_waddr", k, a_wa, m_wa[k]);
        chk("fc_ready", k, int'(fcr[k]), e_fcr);
        chk("acc_clr", k, int'(clr[k]), int'(e_beat != 0 && m_fc[k] == 0));
        chk("acc_en", k, int'(en[k]), int'(e_beat != 0 && m_fc[k] != 0));
        chk("res_valid", k, int'(rv[k]), int'(m_phase[k] == 3));
        chk("done", k, int'(done[k]), int'(m_phase[k] == 3 && res_ready));

        if (cv[k] && conv_ready) n_fire[k]++;
        if (clr[k]) n_clr[k]++;
        if (en[k]) n_en[k]++;
        if (done[k]) n_done[k]++;
        if (rv[k]) n_resv[k]++;

        if (rst) begin
            m_phase[k] = 0; m_iss[k] = 0; m_mid[k] = 0; m_fc[k] = 0; m_wa[k] = 0;
        end else begin
            case (m_phase[k])
                0: if (start) begin
                    m_phase[k] = 1; m_iss[k] = 0; m_mid[k] = 0; m_fc[k] = 0; m_wa[k] = 0;
                end
                1, 2: begin
                    if (e_cv != 0 && conv_ready) m_iss[k]++;
                    if (mid_valid && mid_ready && m_mid[k] < n) begin
                        m_mid[k]++;
                        m_wa[k] = (m_wa[k] + 1) % n;
                    end
                    if (e_beat != 0) m_fc[k]++;
                    if (m_phase[k] == 1 && m_iss[k] == n) m_phase[k] = (m_fc[k] == n) ? 3 : 2;
                    else if (m_phase[k] == 2 && m_fc[k] == n) m_phase[k] = 3;
                end
                default: if (res_ready) m_phase[k] = 0;
            endcase
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) check_and_step(k);
        end
    end

    task automatic check_reset_outputs(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_busy"}, k, int'(busy[k]), 0);
            chk({nm, "_conv_valid"}, k, int'(cv[k]), 0);
            chk({nm, "_tile"}, k, (k == 0) ? int'(tile0) : int'(tile1), 0);
            chk({nm, "_waddr"}, k, (k == 0) ? int'(wa0) : int'(wa1), 0);
            chk({nm, "_fc_ready"}, k, int'(fcr[k]), 0);
            chk({nm, "_clr_en"}, k, int'(clr[k]) + int'(en[k]), 0);
            chk({nm, "_res_done"}, k, int'(rv[k]) + int'(done[k]), 0);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget, input string nm);
        int c;
        c = 0;
        while (busy[k] && c < budget) begin
            tick();
            c++;
        end
        chk(nm, k, int'(busy[k]), 0);
    endtask

    int s_fire [2];
    int s_clr  [2];
    int s_en   [2];
    int s_done [2];
    int s_resv [2];

    task automatic snap;
        s_fire = n_fire; s_clr = n_clr; s_en = n_en; s_done = n_done; s_resv = n_resv;
    endtask

    initial begin
        int c;
        int wq[$];
        int last;

        // Reset
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Nominal frame: FC beat two cycles after each mid fire.
        snap();
        pulse_start();
        chk("start_latency_valid", 0, int'(cv[0]), 1);
        chk("start_latency_tile", 0, int'(tile0), 0);
        for (int i = 0; i < 28; i++) begin
            mid_valid = (i < 26);
            fc_valid  = (i >= 2) && (i < 28);
            tick();
        end
        mid_valid = 1'b0;
        fc_valid  = 1'b0;
        chk("nom_res_valid_after_last_beat", 0, int'(rv[0]), 1);
        wait_idle(0, 50, "nom_timeout");
        chk("nom_fires", 0, n_fire[0] - s_fire[0], 26);
        chk("nom_clr", 0, n_clr[0] - s_clr[0], 1);
        chk("nom_en", 0, n_en[0] - s_en[0], 25);
        chk("nom_done", 0, n_done[0] - s_done[0], 1);
        chk("nom_waddr_wrapped", 0, int'(wa0), 0);

        // Conv backpressure at 1/3 duty.
        snap();
        mid_valid = 1'b1;
        fc_valid  = 1'b1;
        pulse_start();
        c = 0;
        while (busy[0] && c < 300) begin
            conv_ready = (c % 3 == 2);
            tick();
            c++;
        end
        conv_ready = 1'b1;
        chk("bp_timeout", 0, int'(busy[0]), 0);
        chk("bp_fires", 0, n_fire[0] - s_fire[0], 26);
        chk("bp_clr", 0, n_clr[0] - s_clr[0], 1);
        chk("bp_en", 0, n_en[0] - s_en[0], 25);
        chk("bp_done", 0, n_done[0] - s_done[0], 1);

        // Downstream stall with ignored start pulses.
        snap();
        res_ready = 1'b0;
        pulse_start();
        c = 0;
        while (!rv[0] && c < 100) begin
            tick();
            c++;
        end
        chk("stall_reach_out", 0, int'(rv[0]), 1);
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
        end
        start = 1'b0;
        chk("stall_res_valid_held", 0, int'(rv[0]), 1);
        chk("stall_no_done", 0, n_done[0] - s_done[0], 0);
        res_ready = 1'b1;
        #1;
        chk("stall_done_in_accept", 0, int'(done[0]), 1);
        tick();
        chk("stall_idle_after_accept", 0, int'(busy[0]), 0);
        chk("stall_resv_cycles", 0, int'((n_resv[0] - s_resv[0]) >= 11), 1);
        chk("stall_done_once", 0, n_done[0] - s_done[0], 1);
        mid_valid = 1'b0;
        fc_valid  = 1'b0;

        // Reset mid-frame after 12 conv fires.
        snap();
        mid_valid = 1'b1;
        fc_valid  = 1'b1;
        pulse_start();
        c = 0;
        while ((n_fire[0] - s_fire[0]) < 12 && c < 50) begin
            tick();
            c++;
        end
        chk("rstmid_tile12", 0, int'(tile0), 12);
        rst = 1'b1;
        tick();
        check_reset_outputs("rstmid");
        rst = 1'b0;
        mid_valid = 1'b0;
        fc_valid  = 1'b0;
        tick();
        pulse_start();
        chk("rstmid_fresh_valid", 0, int'(cv[0]), 1);
        chk("rstmid_fresh_tile", 0, int'(tile0), 0);
        chk("rstmid_fresh_waddr", 0, int'(wa0), 0);
        mid_valid = 1'b1;
        fc_valid  = 1'b1;
        wait_idle(0, 100, "rstmid_timeout");

        // Simultaneous mid fire and FC beat every cycle.
        pulse_start();
        for (int i = 0; i < 25; i++) tick();
        chk("sim_not_out_at_25", 0, int'(rv[0]), 0);
        tick();
        chk("sim_out_after_beat26", 0, int'(rv[0]), 1);
        wait_idle(0, 20, "sim_timeout");

        // Extra mid fire beyond NTILE while RUN is held by a conv stall.
        pulse_start();
        for (int i = 0; i < 25; i++) tick();
        conv_ready = 1'b0;
        tick();
        chk("extra_waddr_after26", 0, int'(wa0), 0);
        tick();
        chk("extra_waddr_after27", 0, int'(wa0), 0);
        chk("extra_still_run", 0, int'(rv[0]), 0);
        chk("extra_tile25_held", 0, int'(tile0), 25);
        conv_ready = 1'b1;
        tick();
        chk("extra_out_after_last_fire", 0, int'(rv[0]), 1);
        wait_idle(0, 20, "extra_timeout");
        wait_idle(1, 20, "extra_timeout");

        // Small NTILE: waddr sequence, clr/en counts and back-to-back gap.
        snap();
        pulse_start();
        wq.push_back(int'(wa1));
        last = int'(wa1);
        c = 0;
        while (!done[1] && c < 20) begin
            tick();
            c++;
            if (int'(wa1) != last) begin
                last = int'(wa1);
                wq.push_back(last);
            end
        end
        chk("small_done_seen", 1, int'(done[1]), 1);
        chk("small_waddr_seq_len", 1, wq.size(), 3);
        if (wq.size() >= 3) begin
            chk("small_waddr_seq0", 1, wq[0], 0);
            chk("small_waddr_seq1", 1, wq[1], 1);
            chk("small_waddr_seq2", 1, wq[2], 0);
        end
        tick();
        chk("small_gap_idle", 1, int'(busy[1]) + int'(cv[1]), 0);
        pulse_start();
        chk("small_gap_valid", 1, int'(cv[1]), 1);
        chk("small_clr", 1, n_clr[1] - s_clr[1], 1);
        chk("small_en", 1, n_en[1] - s_en[1], 1);
        wait_idle(1, 20, "small_timeout");
        wait_idle(0, 100, "small_dut0_timeout");
        mid_valid = 1'b0;
        fc_valid  = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
